// File: rtl/tdc_pkg.sv
// Shared types for the multi-stop TDC coarse counter.
// Default geometry, FSM states, record flags and record layout.
package tdc_pkg;

   localparam int CW_DEF    = 8;
   localparam int NSTOP_DEF = 4;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CHW_DEF = ch_width(NSTOP_DEF);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      DRAIN
   } state_t;

   typedef enum logic [1:0] {
      NORMAL  = 2'b00,
      COINC   = 2'b01,
      TIMEOUT = 2'b10
   } flag_t;

   typedef struct packed {
      logic [CHW_DEF-1:0] ch;
      logic [CW_DEF-1:0]  code;
      flag_t              flag;
   } record_t;

endpackage

// File: rtl/tdc_stop_latch.sv
// Per-channel first-stop latch: hit bit plus captured code and flag.
// A capture wins over a clear so a fresh start can record a coincident stop.
module tdc_stop_latch
   import tdc_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          cap_i,
   input  logic [CW-1:0] code_i,
   input  flag_t         flag_i,
   output logic          hit_o,
   output logic [CW-1:0] code_o,
   output flag_t         flag_o
);

   logic          hit_q, hit_d;
   logic [CW-1:0] code_q, code_d;
   flag_t         flag_q, flag_d;

   always_comb begin
      hit_d  = hit_q;
      code_d = code_q;
      flag_d = flag_q;
      if (cap_i) begin
         hit_d  = 1'b1;
         code_d = code_i;
         flag_d = flag_i;
      end else if (clr_i) begin
         hit_d  = 1'b0;
         code_d = '0;
         flag_d = NORMAL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_q  <= 1'b0;
         code_q <= '0;
         flag_q <= NORMAL;
      end else begin
         hit_q  <= hit_d;
         code_q <= code_d;
         flag_q <= flag_d;
      end
   end

   assign hit_o  = hit_q;
   assign code_o = code_q;
   assign flag_o = flag_q;

endmodule

// File: rtl/tdc_multi_stop_counter.sv
// Coarse TDC counter: one start, first stop per channel, then drains
// one record per channel over a valid/ready stream.
module tdc_multi_stop_counter #(
   parameter int CW      = tdc_pkg::CW_DEF,
   parameter int NSTOP   = tdc_pkg::NSTOP_DEF,
   parameter int TIMEOUT = (2**CW) - 1,
   parameter int RETRIG  = 0,
   localparam int CHW    = tdc_pkg::ch_width(NSTOP)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NSTOP-1:0] stop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CHW-1:0]   out_ch,
   output logic [CW-1:0]    out_code,
   output logic [1:0]       out_flag,
   output logic             busy,
   output logic             start_lost
);

   import tdc_pkg::*;

   if (NSTOP < 1 || TIMEOUT < 1 || TIMEOUT > (2**CW) - 1) begin : g_bad_param
      $error("tdc_multi_stop_counter: illegal CW/NSTOP/TIMEOUT");
   end

   localparam logic [CW-1:0]  TO_C = CW'(TIMEOUT);
   localparam logic [CHW-1:0] LAST = CHW'(NSTOP - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    k_q, k_d, kn;
   logic [CHW-1:0]   idx_q, idx_d, idx_n;
   logic             ov_q, ov_d, busy_q, busy_d, lost_q, lost_d;
   logic [CHW-1:0]   ch_q, ch_d;
   logic [CW-1:0]    ocode_q, ocode_d;
   flag_t            oflag_q, oflag_d;

   logic [NSTOP-1:0] hit, clr, cap;
   logic [CW-1:0]    cap_code;
   flag_t            cap_flag [NSTOP];
   logic [CW-1:0]    lcode [NSTOP];
   flag_t            lflag [NSTOP];
   logic             fresh, to_drain;

   for (genvar g = 0; g < NSTOP; g++) begin : g_ch
      tdc_stop_latch #(.CW(CW)) u_latch (
         .clk    (clk),
         .rst    (rst),
         .clr_i  (clr[g]),
         .cap_i  (cap[g]),
         .code_i (cap_code),
         .flag_i (cap_flag[g]),
         .hit_o  (hit[g]),
         .code_o (lcode[g]),
         .flag_o (lflag[g])
      );
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      idx_d    = idx_q;
      ov_d     = ov_q;
      ch_d     = ch_q;
      ocode_d  = ocode_q;
      oflag_d  = oflag_q;
      lost_d   = 1'b0;
      clr      = '0;
      cap      = '0;
      cap_code = '0;
      to_drain = 1'b0;
      for (int i = 0; i < NSTOP; i++) cap_flag[i] = NORMAL;
      kn    = k_q + CW'(1);
      idx_n = idx_q + CHW'(1);
      fresh = start && (state_q == IDLE ||
                        (state_q == COUNT && RETRIG != 0));

      if (fresh) begin
         clr     = '1;
         cap     = stop;
         k_d     = '0;
         state_d = COUNT;
         for (int i = 0; i < NSTOP; i++) cap_flag[i] = COINC;
         if (&stop) to_drain = 1'b1;
      end else begin
         lost_d = start && (state_q != IDLE);
         unique case (state_q)
            COUNT: begin
               k_d      = kn;
               cap_code = kn;
               cap      = stop & ~hit;
               if (&(hit | stop)) begin
                  to_drain = 1'b1;
               end else if (kn == TO_C) begin
                  // stops on the final count still win over the timeout
                  to_drain = 1'b1;
                  cap      = ~hit;
                  for (int i = 0; i < NSTOP; i++)
                     cap_flag[i] = stop[i] ? NORMAL : tdc_pkg::TIMEOUT;
               end
            end
            DRAIN: begin
               if (ov_q && out_ready) begin
                  if (idx_q == LAST) begin
                     state_d = IDLE;
                     ov_d    = 1'b0;
                     idx_d   = '0;
                     ch_d    = '0;
                     ocode_d = '0;
                     oflag_d = NORMAL;
                  end else begin
                     idx_d   = idx_n;
                     ch_d    = idx_n;
                     ocode_d = lcode[idx_n];
                     oflag_d = lflag[idx_n];
                  end
               end
            end
            default: ;
         endcase
      end

      // record 0 is loaded from the values being captured on this edge
      if (to_drain) begin
         state_d = DRAIN;
         ov_d    = 1'b1;
         idx_d   = '0;
         ch_d    = '0;
         ocode_d = cap[0] ? cap_code : lcode[0];
         oflag_d = cap[0] ? cap_flag[0] : lflag[0];
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         idx_q   <= '0;
         ov_q    <= 1'b0;
         ch_q    <= '0;
         ocode_q <= '0;
         oflag_q <= NORMAL;
         busy_q  <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         idx_q   <= idx_d;
         ov_q    <= ov_d;
         ch_q    <= ch_d;
         ocode_q <= ocode_d;
         oflag_q <= oflag_d;
         busy_q  <= busy_d;
         lost_q  <= lost_d;
      end
   end

   assign out_valid  = ov_q;
   assign out_ch     = ch_q;
   assign out_code   = ocode_q;
   assign out_flag   = oflag_q;
   assign busy       = busy_q;
   assign start_lost = lost_q;

endmodule

// File: tb/tb_tdc_multi_stop_counter.sv
// Directed bench: dut a (RETRIG=0) and dut b (RETRIG=1), both TIMEOUT=20,
// driven by the same stimulus; expected records are hand-computed.
module tb_tdc_multi_stop_counter;

   localparam int NRM = 0;
   localparam int CNC = 1;
   localparam int TMO = 2;

   logic       clk = 1'b0;
   logic       rst, start, out_ready;
   logic [3:0] stop;

   logic       va, vb, ba, bb, la, lb;
   logic [1:0] cha, chb, fa, fb;
   logic [7:0] coa, cob;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tdc_multi_stop_counter #(
      .CW(8), .NSTOP(4), .TIMEOUT(20), .RETRIG(0)
   ) dut_a (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .out_valid  (va),
      .out_ready  (out_ready),
      .out_ch     (cha),
      .out_code   (coa),
      .out_flag   (fa),
      .busy       (ba),
      .start_lost (la)
   );

   tdc_multi_stop_counter #(
      .CW(8), .NSTOP(4), .TIMEOUT(20), .RETRIG(1)
   ) dut_b (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .out_valid  (vb),
      .out_ready  (out_ready),
      .out_ch     (chb),
      .out_code   (cob),
      .out_flag   (fb),
      .busy       (bb),
      .start_lost (lb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic take(input string tag, input int ch,
                       input int ca, input int fae,
                       input int cb, input int fbe);
      chk({tag, "_va"}, 32'(va), 32'd1);
      chk({tag, "_cha"}, 32'(cha), ch);
      chk({tag, "_coa"}, 32'(coa), ca);
      chk({tag, "_fa"}, 32'(fa), fae);
      chk({tag, "_vb"}, 32'(vb), 32'd1);
      chk({tag, "_chb"}, 32'(chb), ch);
      chk({tag, "_cob"}, 32'(cob), cb);
      chk({tag, "_fb"}, 32'(fb), fbe);
      tick();
   endtask

   task automatic rec(input string tag, input int ch,
                      input int c, input int f);
      take(tag, ch, c, f, c, f);
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_va0"}, 32'(va), 32'd0);
      chk({tag, "_vb0"}, 32'(vb), 32'd0);
      chk({tag, "_ba0"}, 32'(ba), 32'd0);
      chk({tag, "_bb0"}, 32'(bb), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      stop = 4'b0000;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", 32'(va), 32'd0);
      chk("rst_ch", 32'(cha), 32'd0);
      chk("rst_code", 32'(coa), 32'd0);
      chk("rst_flag", 32'(fa), 32'd0);
      chk("rst_busy", 32'(ba), 32'd0);
      chk("rst_lost", 32'(la), 32'd0);
      rst = 1'b0;
      tick();
      idle_chk("rst_idle");

      // basic measurement
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_busy_a", 32'(ba), 32'd1);
      chk("t1_busy_b", 32'(bb), 32'd1);
      tick();
      tick();
      stop = 4'b0001;
      tick();
      stop = 4'b0000;
      tick();
      stop = 4'b0110;
      tick();
      stop = 4'b0000;
      repeat (3) tick();
      chk("t1_nov", 32'(va), 32'd0);
      stop = 4'b1000;
      tick();
      stop = 4'b0000;
      rec("t1_r0", 0, 3, NRM);
      rec("t1_r1", 1, 5, NRM);
      rec("t1_r2", 2, 5, NRM);
      rec("t1_r3", 3, 9, NRM);
      idle_chk("t1_end");

      // coincident stop on ch1
      start = 1'b1;
      stop = 4'b0010;
      tick();
      start = 1'b0;
      stop = 4'b0000;
      repeat (3) tick();
      stop = 4'b1101;
      tick();
      stop = 4'b0000;
      rec("t2_r0", 0, 4, NRM);
      rec("t2_r1", 1, 0, CNC);
      rec("t2_r2", 2, 4, NRM);
      rec("t2_r3", 3, 4, NRM);
      idle_chk("t2_end");

      // full timeout
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      chk("t3_nov", 32'(va), 32'd0);
      chk("t3_busy", 32'(ba), 32'd1);
      tick();
      for (int i = 0; i < 4; i++)
         rec($sformatf("t3_r%0d", i), i, 20, TMO);
      idle_chk("t3_end");

      // stop exactly on the timeout count
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      stop = 4'b0100;
      tick();
      stop = 4'b0000;
      rec("t3b_r0", 0, 20, TMO);
      rec("t3b_r1", 1, 20, TMO);
      rec("t3b_r2", 2, 20, NRM);
      rec("t3b_r3", 3, 20, TMO);
      idle_chk("t3b_end");

      // backpressure plus start during drain
      out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      stop = 4'b0001;
      tick();
      stop = 4'b1110;
      tick();
      stop = 4'b0000;
      chk("t4_v", 32'(va), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_lost_a", 32'(la), 32'd1);
      chk("t4_lost_b", 32'(lb), 32'd1);
      chk("t4_hold_code", 32'(coa), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("t4_nolost%0d", i), 32'(la), 32'd0);
         chk($sformatf("t4_hold_v%0d", i), 32'(va), 32'd1);
         chk($sformatf("t4_hold_ch%0d", i), 32'(cha), 32'd0);
         chk($sformatf("t4_hold_c%0d", i), 32'(coa), 32'd1);
      end
      out_ready = 1'b1;
      rec("t4_r0", 0, 1, NRM);
      rec("t4_r1", 1, 2, NRM);
      rec("t4_r2", 2, 2, NRM);
      rec("t4_r3", 3, 2, NRM);
      idle_chk("t4_end");

      // second start at +6: a ignores it, b restarts
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_lost_a", 32'(la), 32'd1);
      chk("t5_lost_b", 32'(lb), 32'd0);
      chk("t5_busy_b", 32'(bb), 32'd1);
      tick();
      stop = 4'b1111;
      tick();
      stop = 4'b0000;
      for (int i = 0; i < 4; i++)
         take($sformatf("t5_r%0d", i), i, 8, NRM, 2, NRM);
      idle_chk("t5_end");

      // reset in the middle of a measurement
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      stop = 4'b0001;
      tick();
      stop = 4'b0000;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_chk("t6_rst");
      chk("t6_code", 32'(coa), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      stop = 4'b1110;
      tick();
      stop = 4'b0000;
      chk("t6_nostale", 32'(va), 32'd0);
      tick();
      stop = 4'b0001;
      tick();
      stop = 4'b0000;
      rec("t6_r0", 0, 4, NRM);
      rec("t6_r1", 1, 2, NRM);
      rec("t6_r2", 2, 2, NRM);
      rec("t6_r3", 3, 2, NRM);
      idle_chk("t6_end");

      // every channel coincident: straight to drain
      start = 1'b1;
      stop = 4'b1111;
      tick();
      start = 1'b0;
      stop = 4'b0000;
      for (int i = 0; i < 4; i++)
         rec($sformatf("t7_r%0d", i), i, 0, CNC);
      idle_chk("t7_end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
